// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the sequential HI/LO multiply/divide unit.
// Operation codes follow the op[1:0] field driven by the decoder.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: the one (WIDTH+1)-bit add/subtract shared by every
// phase of the multiply/divide sequence.
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_sub ? (i_x - i_y) : (i_x + i_y);

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Shift-add multiply and restoring divide over WIDTH iterations.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_abort,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           r_state, w_next;
    op_e              r_op;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
    logic [WIDTH-1:0] r_acc_hi, r_acc_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_na, r_nb, r_sq, r_sr, r_dz;

    logic             w_div, w_signed, w_go, w_bzero;
    logic             w_ina, w_inb;
    logic [WIDTH:0]   w_x, w_y, w_sum;
    logic             w_sub;

    assign w_div    = (r_op == OP_DIVU) || (r_op == OP_DIV);
    assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_bzero  = (r_b == '0);
    assign w_go     = i_start && !i_abort &&
                      (r_state == S_IDLE || r_state == S_DONE);
    assign w_ina    = (i_op[0] == 1'b1) && i_a[WIDTH-1];
    assign w_inb    = (i_op[0] == 1'b1) && i_b[WIDTH-1];

    muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .i_x   (w_x),
        .i_y   (w_y),
        .i_sub (w_sub),
        .o_sum (w_sum)
    );

    // b is never made positive: its sign flips add/sub in RUN instead
    always_comb begin
        w_x   = '0;
        w_y   = '0;
        w_sub = 1'b0;
        unique case (r_state)
            S_PREP: begin
                w_y   = {1'b0, r_a};
                w_sub = 1'b1;
            end
            S_RUN: begin
                if (w_div) begin
                    w_x   = {r_acc_hi, r_acc_lo[WIDTH-1]};
                    w_y   = {r_nb, r_b};
                    w_sub = !r_nb;
                end else begin
                    w_x = {w_signed & r_acc_hi[WIDTH-1], r_acc_hi};
                    if (r_acc_lo[0]) begin
                        w_y   = {w_signed & r_b[WIDTH-1], r_b};
                        w_sub = r_na;
                    end
                end
            end
            S_FIX: begin
                w_y   = {1'b0, r_acc_lo};
                w_sub = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_go) w_next = S_PREP;
            S_PREP: begin
                if (i_abort)              w_next = S_IDLE;
                else if (w_div && w_bzero) w_next = S_DONE;
                else                      w_next = S_RUN;
            end
            S_RUN: begin
                if (i_abort)            w_next = S_IDLE;
                else if (r_cnt == LAST) w_next = S_FIX;
            end
            S_FIX:  w_next = i_abort ? S_IDLE : S_DONE;
            S_DONE: w_next = w_go ? S_PREP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= OP_MULTU;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_na     <= 1'b0;
            r_nb     <= 1'b0;
            r_sq     <= 1'b0;
            r_sr     <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        r_op <= op_e'(i_op);
                        r_a  <= i_a;
                        r_b  <= i_b;
                        r_na <= w_ina;
                        r_nb <= w_inb;
                        r_sq <= w_ina ^ w_inb;
                        r_sr <= w_ina;
                        r_dz <= 1'b0;
                    end else begin
                        if (i_hi_we) r_hi <= i_wdata;
                        if (i_lo_we) r_lo <= i_wdata;
                    end
                end
                S_PREP: begin
                    if (!i_abort) begin
                        if (w_div && w_bzero) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                            r_dz <= 1'b1;
                        end else begin
                            r_acc_hi <= '0;
                            r_acc_lo <= r_na ? w_sum[WIDTH-1:0] : r_a;
                            r_cnt    <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_div) begin
                        r_acc_hi <= w_sum[WIDTH:1];
                        r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    end else if (!w_sum[WIDTH]) begin
                        r_acc_hi <= w_sum[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc_hi <= {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!i_abort) begin
                        if (w_div) begin
                            r_lo <= r_sq ? w_sum[WIDTH-1:0] : r_acc_lo;
                            r_hi <= r_sr ? (~r_acc_hi + 1'b1) : r_acc_hi;
                        end else begin
                            r_hi <= r_acc_hi;
                            r_lo <= r_acc_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_busy     = (r_state == S_PREP) || (r_state == S_RUN) ||
                        (r_state == S_FIX);
    assign o_done     = (r_state == S_DONE);
    assign o_div_zero = o_done && r_dz;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq; a reference model
// built on 64-bit arithmetic predicts HI/LO for each launched op.
module tb_muldiv_seq;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        abort = 1'b0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [31:0] cur_hi = '0, cur_lo = '0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .i_abort    (abort),
        .i_hi_we    (hi_we),
        .i_lo_we    (lo_we),
        .i_wdata    (wdata),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_busy     (busy),
        .o_done     (done),
        .o_div_zero (div_zero)
    );

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [31:0] x, y);
        exp_t        e;
        logic [63:0] pu;
        longint      sx, sy, p, q, r;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin
                pu = {32'b0, x} * {32'b0, y};
                e.hi = pu[63:32];
                e.lo = pu[31:0];
            end
            2'b01: begin
                p = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (y == 0) begin
                    e.hi = x;
                    e.lo = 32'hFFFFFFFF;
                    e.dz = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = x / y;
                    e.hi = x % y;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                e = sb.pop_front();
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
                check("div_zero", 64'(div_zero), 64'(e.dz));
            end
        end
    end

    // Called at a negedge with the DUT in IDLE or DONE.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, y,
                          input bit wr_start, input int wr_at);
        exp_t        e;
        int          lat, nbusy, explat;
        logic [31:0] ph;
        ph = cur_hi;
        e  = model(o, x, y);
        sb.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        if (wr_start) begin
            hi_we = 1'b1;
            wdata = 32'h5A5A5A5A;
        end
        lat = 0;
        nbusy = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr_start && n == 1) begin
                hi_we = 1'b0;
                check("write_with_start", 64'(hi), 64'(ph));
            end
            if (wr_at > 0 && n == wr_at) begin
                hi_we = 1'b1;
                wdata = 32'hDEADBEEF;
            end
            if (wr_at > 0 && n == wr_at + 1) begin
                hi_we = 1'b0;
                check("mthi_while_busy", 64'(hi), 64'(ph));
            end
            if (busy) nbusy++;
            if (done) begin
                lat = n;
                break;
            end
        end
        explat = (o[1] && y == 0) ? 2 : 35;
        check("latency", 64'(lat), 64'(explat));
        check("busy_cycles", 64'(nbusy), 64'(explat - 1));
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ph, pl;
        bit          seen;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        @(negedge clk);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        run_op(2'b01, 32'h80000000, 32'h00000002, 1'b0, 0);
        run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0, 0);
        @(negedge clk);
        run_op(2'b10, 32'h00000007, 32'h00000002, 1'b0, 0);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
        @(negedge clk);
        run_op(2'b10, 32'h00001234, 32'h00000000, 1'b0, 0);
        run_op(2'b00, 32'h00010001, 32'h00020003, 1'b0, 5);
        run_op(2'b11, 32'h00000064, 32'hFFFFFFF9, 1'b1, 0);

        // abort mid-RUN: no done, HI/LO untouched
        @(negedge clk);
        ph = cur_hi;
        pl = cur_lo;
        start = 1'b1; op = 2'b01; a = 32'h12345678; b = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'h0);
        check("abort_hi", 64'(hi), 64'(ph));
        check("abort_lo", 64'(lo), 64'(pl));
        lo_we = 1'b1;
        wdata = 32'hAAAA5555;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_idle", 64'(lo), 64'hAAAA5555);
        cur_lo = 32'hAAAA5555;
        hi_we = 1'b1;
        wdata = 32'h13572468;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h13572468);
        cur_hi = 32'h13572468;

        start = 1'b1; abort = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 64'(busy), 64'h0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op(ro, ra, rb, 1'b0, 0);
        end

        // synchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hFFFF0000; b = 32'h0000FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_hi", 64'(hi), 64'h0);
        check("midrun_rst_lo", 64'(lo), 64'h0);
        check("midrun_rst_busy", 64'(busy), 64'h0);
        check("midrun_rst_done", 64'(done), 64'h0);
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
        run_op(2'b10, 32'd100, 32'd7, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
